// File: rtl/comm_arbiter.sv
// comm_arbiter: round-robin arbiter sharing one CommMaster command
// transmitter between NREQ requesters. The winner's command is latched,
// launched with a one-cycle snd_cmd, and the winner gets a one-cycle
// gnt/err pulse when cmd_cmplt rises or the wait times out.
module comm_arbiter #(
  parameter int NREQ    = 4,
  parameter int CMD_W   = 16,
  parameter int TIMEOUT = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       gnt,
  output logic                  err,
  output logic                  busy,
  output logic [CMD_W-1:0]      cmd,
  output logic                  snd_cmd,
  input  logic                  cmd_cmplt
);

  localparam int          IDX_W = $clog2(NREQ);
  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned NR    = NREQ;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic             cmplt_q;

  logic             found;
  logic [IDX_W-1:0] winner;
  int unsigned      idx;
  logic             cmplt_rise;

  // Round-robin pick: first requesting index scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = (32'(ptr) + i) % NR;
      if (!found && req[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign cmplt_rise = cmd_cmplt & ~cmplt_q;

  // Arbitration FSM; every output is a register set on the transition into
  // the state in which it must be visible. The timeout fires when the WAIT
  // counter reaches TIMEOUT, which puts gnt exactly TIMEOUT+2 cycles after snd_cmd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snd_cmd <= 1'b0;
      gnt     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      cmd     <= '0;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      cmplt_q <= 1'b1;
    end else begin
      cmplt_q <= cmd_cmplt;
      snd_cmd <= 1'b0;
      gnt     <= '0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            cmd     <= req_cmd[winner*CMD_W +: CMD_W];
            owner   <= winner;
            snd_cmd <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cmplt_rise) begin
            gnt   <= ONE << owner;
            err   <= 1'b0;
            state <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            gnt   <= ONE << owner;
            err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ptr   <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
